stream_demux_1to2: RTL

//  Packet-aware 1-to-2 stream demultiplexer: the receive-side counterpart of the 2:1 select path.
//  One valid/ready input stream is routed beat-by-beat to one of two registered output streams.
//  The route is taken from s_sel on the first beat of a packet and held until the s_last beat.

---
 rtl/stream_demux_1to2.sv | 117 +++++++++++
 1 files changed

// File: rtl/stream_demux_1to2.sv
// Packet-aware 1-to-2 stream demultiplexer.
// The first beat of a packet picks the destination from s_sel. That route is
// held until the s_last beat has been accepted. Each output port has a single
// register stage, so a stalled consumer blocks the source only while its port
// is the current target.
module stream_demux_1to2 #(
  parameter int DATA_W    = 8,
  parameter int PKT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_last,
  input  logic                 s_sel,
  output logic                 m0_valid,
  input  logic                 m0_ready,
  output logic [DATA_W-1:0]    m0_data,
  output logic                 m0_last,
  output logic                 m1_valid,
  input  logic                 m1_ready,
  output logic [DATA_W-1:0]    m1_data,
  output logic                 m1_last,
  output logic [PKT_CNT_W-1:0] pkt_cnt0,
  output logic [PKT_CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state;
  logic   tgt;
  logic   free0;
  logic   free1;
  logic   acc;
  logic   load0;
  logic   load1;

  // Route selection and input handshake. s_ready never looks at s_valid.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    tgt = 1'b0;
    unique case (state)
      IDLE:    tgt = s_sel;
      LOCK0:   tgt = 1'b0;
      LOCK1:   tgt = 1'b1;
      default: tgt = 1'b0;
    endcase
    free0   = !m0_valid || m0_ready;
    free1   = !m1_valid || m1_ready;
    s_ready = tgt ? free1 : free0;
    acc     = s_valid && s_ready;
    load0   = acc && !tgt;
    load1   = acc && tgt;
  end

  // Route-lock FSM: the lock opens on a non-last first beat and closes on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
    end else if (acc) begin
      unique case (state)
        IDLE:    if (!s_last) state <= s_sel ? LOCK1 : LOCK0;
        LOCK0,
        LOCK1:   if (s_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port 0 output register. It reloads on the same edge it drains, which gives full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_valid <= 1'b0;
      m0_data  <= '0;
      m0_last  <= 1'b0;
    end else if (load0) begin
      m0_valid <= 1'b1;
      m0_data  <= s_data;
      m0_last  <= s_last;
    end else if (m0_ready) begin
      m0_valid <= 1'b0;
    end
  end

  // Port 1 output register. It mirrors port 0 and is fully independent of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_valid <= 1'b0;
      m1_data  <= '0;
      m1_last  <= 1'b0;
    end else if (load1) begin
      m1_valid <= 1'b1;
      m1_data  <= s_data;
      m1_last  <= s_last;
    end else if (m1_ready) begin
      m1_valid <= 1'b0;
    end
  end

  // Completed-packet counters. They bump on each accepted last beat and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (load0 && s_last) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (load1 && s_last) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end

endmodule
